// File: rtl/npu_pkg.sv
// Shared NPU definitions used by the fully-connected layer datapath.
//   FC_DATA_W : operand width for activations and weights
//   FC_ACC_W  : accumulator width for partial sums
//   data_t    : signed operand type
//   acc_t     : signed accumulator type
package npu_pkg;

  localparam int unsigned FC_DATA_W = 22;
  localparam int unsigned FC_ACC_W  = 48;

  typedef logic signed [FC_DATA_W-1:0] data_t;
  typedef logic signed [FC_ACC_W-1:0]  acc_t;

endpackage : npu_pkg

// File: rtl/mac_mult.sv
// Combinational signed multiplier, kept as its own module so synthesis can
// map it onto a DSP block.
//   a : signed A_W-bit operand
//   b : signed B_W-bit operand
//   p : full-precision signed product, A_W+B_W bits (never overflows)
module mac_mult #(
  parameter int unsigned A_W = 22,
  parameter int unsigned B_W = 22
) (
  input  logic signed [A_W-1:0]     a,
  input  logic signed [B_W-1:0]     b,
  output logic signed [A_W+B_W-1:0] p
);

  always_comb begin
    p = a * b;
  end

endmodule : mac_mult

// File: rtl/mac_unit.sv
// Single-cycle signed multiply-accumulate: sum_out <= sum_in + a*b.
// The caller owns the accumulator and feeds it back on sum_in.
//   clk       : clock, rising edge
//   rst       : asynchronous, active-low reset
//   i_valid   : operands and sum_in valid this cycle
//   data_in_a : signed activation operand (A_W)
//   data_in_b : signed weight operand (B_W)
//   sum_in    : signed partial sum (ACC_W)
//   o_valid   : sum_out was updated by the previous-cycle i_valid
//   sum_out   : registered signed MAC result (ACC_W)
// ACC_W must be >= A_W+B_W. SATURATE=0 wraps, SATURATE=1 clamps to signed min/max.
module mac_unit
  import npu_pkg::*;
#(
  parameter int unsigned A_W      = FC_DATA_W,
  parameter int unsigned B_W      = FC_DATA_W,
  parameter int unsigned ACC_W    = FC_ACC_W,
  parameter bit          SATURATE = 1'b0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_valid,
  input  logic signed [A_W-1:0]   data_in_a,
  input  logic signed [B_W-1:0]   data_in_b,
  input  logic signed [ACC_W-1:0] sum_in,
  output logic                    o_valid,
  output logic signed [ACC_W-1:0] sum_out
);

  localparam int unsigned P_W = A_W + B_W;

  logic signed [P_W-1:0]   prod;
  logic signed [ACC_W-1:0] prod_ext;
  logic signed [ACC_W-1:0] sum_raw;
  logic signed [ACC_W-1:0] sum_res;
  logic                    ovf;

  logic signed [ACC_W-1:0] sum_d, sum_q;
  logic                    valid_d, valid_q;

  mac_mult #(
    .A_W (A_W),
    .B_W (B_W)
  ) u_mult (
    .a (data_in_a),
    .b (data_in_b),
    .p (prod)
  );

  always_comb begin
    // Size cast of a signed value sign-extends the product to the accumulator width.
    prod_ext = ACC_W'(prod);
    sum_raw  = sum_in + prod_ext;
    // Signed overflow: both addends share a sign that the result does not.
    ovf      = (sum_in[ACC_W-1] == prod_ext[ACC_W-1]) &&
               (sum_raw[ACC_W-1] != sum_in[ACC_W-1]);
    sum_res  = sum_raw;
    if (SATURATE && ovf) begin
      sum_res = sum_in[ACC_W-1] ? {1'b1, {(ACC_W-1){1'b0}}}
                                : {1'b0, {(ACC_W-1){1'b1}}};
    end
  end

  // Hold selection on i_valid keeps X operands of idle cycles out of sum_q.
  always_comb begin
    valid_d = i_valid;
    sum_d   = sum_q;
    if (i_valid) begin
      sum_d = sum_res;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q <= 1'b0;
      sum_q   <= '0;
    end else begin
      valid_q <= valid_d;
      sum_q   <= sum_d;
    end
  end

  assign o_valid = valid_q;
  assign sum_out = sum_q;

endmodule : mac_unit

// File: tb/tb_mac_unit.sv
// Self-checking bench for mac_unit: one wrapping and one saturating instance
// share the same stimulus and are compared against a longint reference model.
module tb_mac_unit;
  import npu_pkg::*;

  localparam longint ACC_MAX = (longint'(1) <<< 47) - 1;
  localparam longint ACC_MIN = -(longint'(1) <<< 47);

  logic  clk = 1'b0;
  logic  rst = 1'b0;
  logic  i_valid = 1'b0;
  data_t da = '0;
  data_t db = '0;
  acc_t  sin = '0;

  logic  ov_w, ov_s;
  acc_t  so_w, so_s;

  int    n_checks = 0;
  int    n_fail   = 0;

  acc_t  exp_w = '0;
  acc_t  exp_s = '0;
  logic  exp_v = 1'b0;

  mac_unit #(
    .A_W      (FC_DATA_W),
    .B_W      (FC_DATA_W),
    .ACC_W    (FC_ACC_W),
    .SATURATE (1'b0)
  ) dut_wrap (
    .clk       (clk),
    .rst       (rst),
    .i_valid   (i_valid),
    .data_in_a (da),
    .data_in_b (db),
    .sum_in    (sin),
    .o_valid   (ov_w),
    .sum_out   (so_w)
  );

  mac_unit #(
    .A_W      (FC_DATA_W),
    .B_W      (FC_DATA_W),
    .ACC_W    (FC_ACC_W),
    .SATURATE (1'b1)
  ) dut_sat (
    .clk       (clk),
    .rst       (rst),
    .i_valid   (i_valid),
    .data_in_a (da),
    .data_in_b (db),
    .sum_in    (sin),
    .o_valid   (ov_s),
    .sum_out   (so_s)
  );

  always #5 clk = ~clk;

  // Reference: exact sum in 64-bit arithmetic, then wrap or clamp to 48 bits.
  function automatic longint exact_mac(input data_t a, input data_t b, input acc_t s);
    return longint'(s) + longint'(a) * longint'(b);
  endfunction

  function automatic acc_t wrap48(input longint x);
    return acc_t'(x);
  endfunction

  function automatic acc_t sat48(input longint x);
    if (x > ACC_MAX) return acc_t'(ACC_MAX);
    if (x < ACC_MIN) return acc_t'(ACC_MIN);
    return acc_t'(x);
  endfunction

  task automatic check(input string tag, input logic [47:0] obs, input logic [47:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, "_valid_w"}, {47'd0, ov_w}, {47'd0, exp_v});
    check({tag, "_valid_s"}, {47'd0, ov_s}, {47'd0, exp_v});
    check({tag, "_sum_w"}, so_w, exp_w);
    check({tag, "_sum_s"}, so_s, exp_s);
  endtask

  task automatic drive(input string tag, input logic v, input data_t a, input data_t b,
                       input acc_t s);
    longint e;
    @(negedge clk);
    i_valid = v;
    da      = a;
    db      = b;
    sin     = s;
    exp_v   = v;
    if (v) begin
      e     = exact_mac(a, b, s);
      exp_w = wrap48(e);
      exp_s = sat48(e);
    end
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  function automatic data_t rand_data();
    return data_t'($urandom);
  endfunction

  function automatic acc_t rand_acc();
    return acc_t'({$urandom, $urandom});
  endfunction

  initial begin
    longint dot;
    data_t  ra, rb;

    // Reset held with random inputs.
    rst = 1'b0;
    for (int unsigned i = 0; i < 3; i++) begin
      @(negedge clk);
      i_valid = 1'b1;
      da  = rand_data();
      db  = rand_data();
      sin = rand_acc();
      @(posedge clk);
      #1;
      check_all("reset");
    end
    @(negedge clk);
    i_valid = 1'b0;
    rst     = 1'b1;

    // Basic directed cases.
    drive("basic", 1'b1, 22'sd3, -22'sd2, 48'sd10);
    check("basic_const", so_w, 48'd4);
    drive("hold", 1'b0, 22'sd7, 22'sd7, 48'sd99);
    check("hold_const", so_w, 48'd4);
    drive("hold_x", 1'b0, 'x, 'x, 'x);

    // Operand extremes.
    drive("minmin", 1'b1, -22'sd2097152, -22'sd2097152, '0);
    check("minmin_const", so_w, 48'h0400_0000_0000);
    drive("minmax", 1'b1, -22'sd2097152, 22'sd2097151, '0);
    check("minmax_const", so_w, 48'hFC00_0020_0000);

    // Overflow in both directions.
    drive("ovf_pos", 1'b1, 22'sd1, 22'sd1, 48'h7FFF_FFFF_FFFF);
    check("ovf_pos_w", so_w, 48'h8000_0000_0000);
    check("ovf_pos_s", so_s, 48'h7FFF_FFFF_FFFF);
    drive("ovf_neg", 1'b1, -22'sd1, 22'sd1, 48'h8000_0000_0000);
    check("ovf_neg_w", so_w, 48'h7FFF_FFFF_FFFF);
    check("ovf_neg_s", so_s, 48'h8000_0000_0000);

    // Random transactions, full-range operands and partial sums.
    for (int unsigned i = 0; i < 60; i++) begin
      drive("rand", ($urandom_range(3) != 0), rand_data(), rand_data(),
            (i % 4 == 0) ? acc_t'(ACC_MAX - longint'($urandom_range(1000))) : rand_acc());
    end

    // Streaming dot product, sum_in fed back from sum_out.
    dot = 0;
    for (int unsigned i = 0; i < 225; i++) begin
      @(negedge clk);
      ra = data_t'($signed($urandom_range(1048575)) - 524288);
      rb = data_t'($signed($urandom_range(1048575)) - 524288);
      i_valid = 1'b1;
      da  = ra;
      db  = rb;
      sin = (i == 0) ? '0 : so_w;
      dot += longint'(ra) * longint'(rb);
      @(posedge clk);
      #1;
      check("stream_valid", {47'd0, ov_w}, 48'd1);
    end
    check("dot_w", so_w, acc_t'(dot));
    check("dot_s", so_s, acc_t'(dot));
    exp_w = acc_t'(dot);
    exp_s = acc_t'(dot);
    exp_v = 1'b1;

    // Reset dropped mid-stream clears outputs at once.
    for (int unsigned i = 0; i < 4; i++) begin
      drive("prerst", 1'b1, rand_data(), rand_data(), rand_acc());
    end
    @(negedge clk);
    i_valid = 1'b1;
    #2;
    rst = 1'b0;
    #1;
    exp_v = 1'b0;
    exp_w = '0;
    exp_s = '0;
    check_all("midrst");
    @(negedge clk);
    check_all("midrst_hold");
    rst = 1'b1;
    drive("resume", 1'b1, 22'sd5, 22'sd6, 48'sd7);
    check("resume_const", so_w, 48'd37);
    for (int unsigned i = 0; i < 5; i++) begin
      drive("resume_rand", 1'b1, rand_data(), rand_data(), rand_acc());
    end
    drive("idle", 1'b0, '0, '0, '0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_mac_unit
